// File: rtl/ula_mc_pkg.sv
// Shared opcode and FSM encodings for the multi-cycle ALU.
// The control-unit decoder imports the same opcode enum.
package ula_pkg;

  localparam int unsigned FUNC_W = 4;

  typedef enum logic [FUNC_W-1:0] {
    ADD   = 4'd0,
    SUB   = 4'd1,
    SLL   = 4'd2,
    SRL   = 4'd3,
    SRA   = 4'd4,
    OR    = 4'd5,
    AND   = 4'd6,
    XOR   = 4'd7,
    MUL   = 4'd8,
    MULHU = 4'd9,
    DIVU  = 4'd10,
    REMU  = 4'd11,
    SLT   = 4'd12,
    SLTU  = 4'd13
  } ula_func_e;

  typedef enum logic {
    IDLE = 1'b0,
    ITER = 1'b1
  } ula_state_e;

  // Opcodes 8..11 run on the iterative unit.
  function automatic logic is_iter_op(input logic [FUNC_W-1:0] f);
    return (f[3:2] == 2'b10);
  endfunction

endpackage

// File: rtl/ula_mc_muldiv.sv
// Iterative unsigned shift-add multiplier and restoring divider.
// One step per cycle; o_res_c is the result produced by the current step.
module ula_muldiv_iter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [1:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_step,
  output logic             o_last_c,
  output logic [WIDTH-1:0] o_res_c
);

  localparam int unsigned CW = $clog2(WIDTH);

  // i_op: 0 MUL, 1 MULHU, 2 DIVU, 3 REMU
  logic [1:0]       r_op;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_b;
  logic [CW-1:0]    r_cnt;

  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_shf;
  logic [WIDTH-1:0] w_diff;
  logic [WIDTH-1:0] w_hi_n;
  logic [WIDTH-1:0] w_lo_n;

  // hi:lo is accumulator:multiplier for MUL, remainder:dividend for DIV.
  always_comb begin
    w_sum  = '0;
    w_shf  = '0;
    w_diff = '0;
    w_hi_n = r_hi;
    w_lo_n = r_lo;
    if (!r_op[1]) begin
      w_sum  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
      w_hi_n = w_sum[WIDTH:1];
      w_lo_n = {w_sum[0], r_lo[WIDTH-1:1]};
    end else begin
      w_shf  = {r_hi, r_lo[WIDTH-1]};
      w_diff = w_shf[WIDTH-1:0] - r_b;
      // Divisor zero always "fits": quotient all ones, remainder = dividend.
      if (w_shf >= {1'b0, r_b}) begin
        w_hi_n = w_diff;
        w_lo_n = {r_lo[WIDTH-2:0], 1'b1};
      end else begin
        w_hi_n = w_shf[WIDTH-1:0];
        w_lo_n = {r_lo[WIDTH-2:0], 1'b0};
      end
    end
  end

  assign o_last_c = (r_cnt == CW'(WIDTH-1));
  assign o_res_c  = r_op[0] ? w_hi_n : w_lo_n;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_op  <= 2'd0;
      r_hi  <= '0;
      r_lo  <= '0;
      r_b   <= '0;
      r_cnt <= '0;
    end else if (i_load) begin
      r_op  <= i_op;
      r_hi  <= '0;
      r_lo  <= i_op[1] ? i_a : i_b;
      r_b   <= i_op[1] ? i_b : i_a;
      r_cnt <= '0;
    end else if (i_step) begin
      r_hi  <= w_hi_n;
      r_lo  <= w_lo_n;
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/ula_mc.sv
// Multi-cycle ALU: single-cycle datapath, IDLE/ITER FSM and registered
// result/flags with a start/ready/done handshake.
module ula_mc
  import ula_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [FUNC_W-1:0] func,
  input  logic [WIDTH-1:0]  in1,
  input  logic [WIDTH-1:0]  in2,
  output logic              ready,
  output logic              done,
  output logic [WIDTH-1:0]  out,
  output logic              z_flag,
  output logic              v_flag
);

  localparam int unsigned MSB = WIDTH - 1;

  ula_state_e       r_state;
  logic             r_ready;
  logic             r_done;
  logic [WIDTH-1:0] r_out;
  logic             r_z;
  logic             r_v;

  ula_func_e        w_func;
  logic [WIDTH-1:0] w_add;
  logic [WIDTH-1:0] w_sub;
  logic [SHW-1:0]   w_sh;
  logic [WIDTH-1:0] w_res;
  logic             w_v;
  logic             w_iter;
  logic             w_load;
  logic             w_last;
  logic [WIDTH-1:0] w_md_res;

  assign w_func = ula_func_e'(func);
  assign w_add  = in1 + in2;
  assign w_sub  = in1 + ~in2 + WIDTH'(1);
  assign w_sh   = in2[SHW-1:0];
  assign w_iter = is_iter_op(func);
  assign w_load = (r_state == IDLE) && start && w_iter;

  // Single-cycle datapath; illegal and iterative codes fall to zero here.
  always_comb begin
    w_res = '0;
    w_v   = 1'b0;
    case (w_func)
      ADD: begin
        w_res = w_add;
        w_v   = (in1[MSB] == in2[MSB]) && (w_add[MSB] != in1[MSB]);
      end
      SUB: begin
        w_res = w_sub;
        w_v   = (in1[MSB] != in2[MSB]) && (w_sub[MSB] != in1[MSB]);
      end
      SLL:  w_res = in1 << w_sh;
      SRL:  w_res = in1 >> w_sh;
      SRA:  w_res = WIDTH'($signed(in1) >>> w_sh);
      OR:   w_res = in1 | in2;
      AND:  w_res = in1 & in2;
      XOR:  w_res = in1 ^ in2;
      SLT:  w_res = {{(WIDTH-1){1'b0}}, ($signed(in1) < $signed(in2))};
      SLTU: w_res = {{(WIDTH-1){1'b0}}, (in1 < in2)};
      default: w_res = '0;
    endcase
  end

  ula_muldiv_iter #(
    .WIDTH (WIDTH)
  ) u_muldiv (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_load   (w_load),
    .i_op     (func[1:0]),
    .i_a      (in1),
    .i_b      (in2),
    .i_step   (r_state == ITER),
    .o_last_c (w_last),
    .o_res_c  (w_md_res)
  );

  // Control FSM and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_ready <= 1'b1;
      r_done  <= 1'b0;
      r_out   <= '0;
      r_z     <= 1'b1;
      r_v     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            if (w_iter) begin
              r_state <= ITER;
              r_ready <= 1'b0;
            end else begin
              r_out  <= w_res;
              r_z    <= (w_res == '0);
              r_v    <= w_v;
              r_done <= 1'b1;
            end
          end
        end
        ITER: begin
          if (w_last) begin
            r_state <= IDLE;
            r_ready <= 1'b1;
            r_out   <= w_md_res;
            r_z     <= (w_md_res == '0);
            r_v     <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  assign ready  = r_ready;
  assign done   = r_done;
  assign out    = r_out;
  assign z_flag = r_z;
  assign v_flag = r_v;

endmodule

// File: tb/tb_ula_mc.sv
// Scoreboard bench for ula_mc: 32-bit directed vectors plus an 8-bit
// instance driven with a back-to-back stream checked against a small model.
module tb_ula_mc;

  typedef struct {
    logic [31:0] o;
    logic        z;
    logic        v;
    int          c;
    string       n;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  logic        start32 = 1'b0;
  logic [3:0]  func32 = 4'd0;
  logic [31:0] a32 = '0, b32 = '0;
  logic        ready32, done32, z32, v32;
  logic [31:0] out32;

  logic        start8 = 1'b0;
  logic [3:0]  func8 = 4'd0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        ready8, done8, z8, v8;
  logic [7:0]  out8;

  exp_t q32[$];
  exp_t q8[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ula_mc #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start32), .func(func32),
    .in1(a32), .in2(b32), .ready(ready32), .done(done32),
    .out(out32), .z_flag(z32), .v_flag(v32)
  );

  ula_mc #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .func(func8),
    .in1(a8), .in2(b8), .ready(ready8), .done(done8),
    .out(out8), .z_flag(z8), .v_flag(v8)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitors: pop one expectation per done pulse.
  always @(negedge clk) begin
    if (done32 === 1'b1) begin
      if (q32.size() == 0) begin
        chk("unexpected_done32", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q32.pop_front();
        chk({e.n, ".out"}, out32, e.o);
        chk({e.n, ".z"}, {31'd0, z32}, {31'd0, e.z});
        chk({e.n, ".v"}, {31'd0, v32}, {31'd0, e.v});
        chk({e.n, ".cycle"}, cyc, e.c);
      end
    end
  end

  always @(negedge clk) begin
    if (done8 === 1'b1) begin
      if (q8.size() == 0) begin
        chk("unexpected_done8", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q8.pop_front();
        chk({e.n, ".out"}, {24'd0, out8}, e.o);
        chk({e.n, ".z"}, {31'd0, z8}, {31'd0, e.z});
        chk({e.n, ".v"}, {31'd0, v8}, {31'd0, e.v});
        chk({e.n, ".cycle"}, cyc, e.c);
      end
    end
  end

  task automatic issue32(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eo, input logic ez, input logic ev, input string n);
    int guard;
    exp_t e;
    guard = 0;
    while (ready32 !== 1'b1 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) chk({n, ".ready_timeout"}, 32'd0, 32'd1);
    start32 = 1'b1; func32 = f; a32 = a; b32 = b;
    e.o = eo; e.z = ez; e.v = ev; e.n = n;
    e.c = cyc + 1 + ((f >= 4'd8 && f <= 4'd11) ? 32 : 0);
    q32.push_back(e);
    @(negedge clk);
    start32 = 1'b0;
  endtask

  task automatic issue8(input logic [3:0] f, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] eo, input logic ez, input logic ev, input string n);
    int guard;
    exp_t e;
    guard = 0;
    while (ready8 !== 1'b1 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) chk({n, ".ready_timeout"}, 32'd0, 32'd1);
    start8 = 1'b1; func8 = f; a8 = a; b8 = b;
    e.o = {24'd0, eo}; e.z = ez; e.v = ev; e.n = n;
    e.c = cyc + 1 + ((f >= 4'd8 && f <= 4'd11) ? 8 : 0);
    q8.push_back(e);
    @(negedge clk);
    start8 = 1'b0;
  endtask

  // Reference for 8-bit single-cycle ops, returns {v, out}.
  function automatic logic [8:0] model8(input logic [3:0] f, input logic [7:0] a, input logic [7:0] b);
    int sa, sb, r;
    logic [7:0] o;
    logic v;
    sa = $signed(a);
    sb = $signed(b);
    v = 1'b0;
    o = 8'd0;
    r = 0;
    case (f)
      4'd0: begin r = sa + sb; v = (r > 127) || (r < -128); o = r[7:0]; end
      4'd1: begin r = sa - sb; v = (r > 127) || (r < -128); o = r[7:0]; end
      4'd2: o = 8'(a << b[2:0]);
      4'd3: o = a >> b[2:0];
      4'd4: begin r = sa >>> b[2:0]; o = r[7:0]; end
      4'd5: o = a | b;
      4'd6: o = a & b;
      4'd7: o = a ^ b;
      4'd12: o = (sa < sb) ? 8'd1 : 8'd0;
      4'd13: o = (a < b) ? 8'd1 : 8'd0;
      default: o = 8'd0;
    endcase
    return {v, o};
  endfunction

  initial begin
    int lowcnt;
    int guard;
    logic [3:0] f;
    logic [7:0] ra, rb;
    logic [8:0] m;

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk("reset.ready", {31'd0, ready32}, 32'd1);
    chk("reset.done", {31'd0, done32}, 32'd0);
    chk("reset.out", out32, 32'd0);
    chk("reset.z", {31'd0, z32}, 32'd1);
    chk("reset.v", {31'd0, v32}, 32'd0);

    // Single-cycle ops, back to back.
    issue32(4'd0, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1'b0, 1'b1, "add_ovf");
    issue32(4'd1, 32'd5, 32'd5, 32'h0, 1'b1, 1'b0, "sub_zero");
    issue32(4'd1, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 1'b0, 1'b1, "sub_ovf");
    issue32(4'd4, 32'h8000_0000, 32'h24, 32'hF800_0000, 1'b0, 1'b0, "sra");
    issue32(4'd2, 32'd1, 32'd31, 32'h8000_0000, 1'b0, 1'b0, "sll");
    issue32(4'd3, 32'h8000_0000, 32'h3F, 32'h1, 1'b0, 1'b0, "srl");
    issue32(4'd12, 32'hFFFF_FFFF, 32'd1, 32'h1, 1'b0, 1'b0, "slt");
    issue32(4'd13, 32'hFFFF_FFFF, 32'd1, 32'h0, 1'b1, 1'b0, "sltu");
    issue32(4'd5, 32'hF0F0_0000, 32'h0000_0F0F, 32'hF0F0_0F0F, 1'b0, 1'b0, "or");
    issue32(4'd6, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'h0F00_0F00, 1'b0, 1'b0, "and");
    issue32(4'd7, 32'hAAAA_AAAA, 32'hFFFF_FFFF, 32'h5555_5555, 1'b0, 1'b0, "xor");
    issue32(4'd14, 32'h1234, 32'h5678, 32'h0, 1'b1, 1'b0, "illegal14");
    issue32(4'd15, 32'h1234, 32'h5678, 32'h0, 1'b1, 1'b0, "illegal15");

    // MUL with ready-low count and an ignored mid-operation start.
    start32 = 1'b1; func32 = 4'd8; a32 = 32'hFFFF_FFFF; b32 = 32'd2;
    begin
      exp_t e;
      e.o = 32'hFFFF_FFFE; e.z = 1'b0; e.v = 1'b0; e.n = "mul"; e.c = cyc + 1 + 32;
      q32.push_back(e);
    end
    @(negedge clk);
    start32 = 1'b0;
    lowcnt = 0;
    while (ready32 === 1'b0 && lowcnt < 40) begin
      lowcnt++;
      if (lowcnt == 5) begin
        start32 = 1'b1; func32 = 4'd0; a32 = 32'd1; b32 = 32'd1;
      end else begin
        start32 = 1'b0;
      end
      @(negedge clk);
    end
    start32 = 1'b0;
    chk("mul.ready_low_cycles", lowcnt, 32'd32);

    issue32(4'd9, 32'hFFFF_FFFF, 32'd2, 32'h1, 1'b0, 1'b0, "mulhu");
    issue32(4'd10, 32'd100, 32'd7, 32'd14, 1'b0, 1'b0, "divu");
    issue32(4'd11, 32'd100, 32'd7, 32'd2, 1'b0, 1'b0, "remu");
    issue32(4'd10, 32'd9, 32'd0, 32'hFFFF_FFFF, 1'b0, 1'b0, "divu_by0");
    issue32(4'd11, 32'd9, 32'd0, 32'd9, 1'b0, 1'b0, "remu_by0");
    issue32(4'd0, 32'd2, 32'd3, 32'd5, 1'b0, 1'b0, "add_after_iter");

    // Reset in the middle of a DIVU: no done may follow.
    guard = 0;
    while (ready32 !== 1'b1 && guard < 100) begin @(negedge clk); guard++; end
    start32 = 1'b1; func32 = 4'd10; a32 = 32'd1000; b32 = 32'd3;
    @(negedge clk);
    start32 = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort.ready", {31'd0, ready32}, 32'd1);
    chk("abort.done", {31'd0, done32}, 32'd0);
    chk("abort.out", out32, 32'd0);
    chk("abort.z", {31'd0, z32}, 32'd1);
    chk("abort.v", {31'd0, v32}, 32'd0);
    repeat (40) @(negedge clk);
    issue32(4'd0, 32'h10, 32'h20, 32'h30, 1'b0, 1'b0, "add_after_abort");

    // 8-bit instance: iterative latency and a back-to-back stream.
    issue8(4'd8, 8'h10, 8'h10, 8'h00, 1'b1, 1'b0, "w8_mul");
    issue8(4'd10, 8'd200, 8'd9, 8'd22, 1'b0, 1'b0, "w8_divu");
    for (int i = 0; i < 24; i++) begin
      int r;
      r = int'($urandom_range(0, 11));
      f = (r < 8) ? 4'(r) : 4'(r + 4);
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      m = model8(f, ra, rb);
      issue8(f, ra, rb, m[7:0], (m[7:0] == 8'd0), m[8], $sformatf("w8_rand%0d_f%0d", i, f));
    end

    guard = 0;
    while ((q32.size() != 0 || q8.size() != 0) && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    chk("drain32", q32.size(), 32'd0);
    chk("drain8", q8.size(), 32'd0);
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ula_mc.md
# ula_mc

Multi-cycle, parametrised ALU (ULA) for the MIPS-Simplificado datapath. It retains the eight single-cycle operations and adds iterative multiply and divide, signed and unsigned compares, an overflow flag, and a start/ready/done handshake. Results and flags are registered, so the control FSM stalls on `ready` instead of assuming combinational settling.

## Interface
- `WIDTH`, default 32: operand and result width, even, ≥ 8.
- `SHW`, default $clog2(WIDTH): number of shift-amount bits taken from `in2`.

- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `start`  in  1  request pulse; accepted only while `ready`=1.
- `func`  in  4  operation code, sampled with `start`.
- `in1`, `in2`  in  WIDTH  operands, sampled with `start`.
- `ready`  out  1  unit idle; a new `start` will be accepted.
- `done`  out  1  one-cycle pulse; `out`/flags updated this cycle.
- `out`  out  WIDTH  result, held until the next `done`.
- `z_flag`  out  1  `out`==0, registered together with `out`.
- `v_flag`  out  1  signed overflow for ADD/SUB; 0 for every other op.

## Operation
- Opcodes: 0 ADD, 1 SUB, 2 SLL, 3 SRL, 4 SRA, 5 OR, 6 AND, 7 XOR, 8 MUL, 9 MULHU, 10 DIVU, 11 REMU, 12 SLT, 13 SLTU. Opcodes 14–15 are illegal: result 0, `z_flag`=1, `v_flag`=0, single-cycle.
- Arithmetic is modulo 2^WIDTH. SUB = in1 + ~in2 + 1.
- Shifts use `in2[SHW-1:0]` only. SRA is arithmetic on `$signed(in1)`.
- SLT/SLTU return 1 or 0 in bit 0 and zeros above.
- MUL returns the low WIDTH bits of the unsigned product. MULHU returns the high WIDTH bits.
- DIVU/REMU are unsigned restoring division. Divide by zero: DIVU = all ones, REMU = `in1`, no exception.
- `v_flag` for ADD: operand signs equal and the result sign differs. For SUB: operand signs differ and the result sign differs from `in1`.
- FSM states:
  - IDLE: `ready`=1.
  - `start` with op 0–7 or 12–15: compute, register the result, stay in IDLE, assert `done` next cycle.
  - `start` with op 8–11: latch operands, clear counter, go to ITER.
  - ITER: `ready`=0. One shift-add or shift-subtract step per cycle. Counter counts 0..WIDTH-1. At WIDTH-1, go to IDLE and register the result.
- `start` while `ready`=0 is ignored; no queuing.
- `func`/`in1`/`in2` changes after acceptance have no effect.

## Timing
- Reset (`rst_n`=0 at an edge): state IDLE, `ready`=1, `done`=0, `out`=0, `z_flag`=1, `v_flag`=0, counter 0. Reset during ITER aborts the operation with no `done`.
- Single-cycle ops: `start` sampled at edge k → `done`=1 in cycle k+1 (1-cycle latency).
- Iterative ops: `start` at edge k → `done`=1 in cycle k+WIDTH+1. `ready` is low in cycles k+1..k+WIDTH.
- `ready`=1 during the `done` cycle, so back-to-back starts give one result per cycle for simple ops.
- `done` is never asserted for two consecutive cycles from a single `start`.

## Structure
- `ula_pkg`: opcode enum `ula_func_e` (4-bit, names above) and FSM enum `ula_state_e` {IDLE, ITER}. Shared with the control unit decoder.
- Sub-module `ula_muldiv_iter`: holds operand and accumulator registers, the counter, and the step logic. Parametrised by WIDTH. `ula_mc` keeps the single-cycle datapath, FSM, and output registers.
- Estimated size: about 250 RTL lines in total.

## Test plan
- Reset, then ADD 0x7FFFFFFF + 1 → `done` at k+1, `out`=0x80000000, `v_flag`=1, `z_flag`=0. Then SUB 5−5 → `out`=0, `z_flag`=1.
- SRA 0x80000000 by `in2`=0x24 (effective shift 4) → 0xF8000000. SLL 1 by 31 → 0x80000000. SLT −1 vs 1 → 1. SLTU same operands → 0.
- MUL 0xFFFFFFFF × 2 → `done` exactly at k+33, `out`=0xFFFFFFFE. MULHU same operands → 0x00000001. `ready`=0 for 32 cycles; a `start` mid-operation is ignored.
- DIVU 100/7 → 14. REMU → 2. DIVU 9/0 → 0xFFFFFFFF. REMU 9/0 → 9.
- `rst_n` low at iteration 10 of a DIVU → no `done`. Outputs return to reset values. A following ADD completes normally.
- `WIDTH`=8 instance: MUL 0x10 × 0x10 → 0x00, `z_flag`=1, latency 9. Random single-cycle back-to-back stream checked against a reference model.
